comparator_bist: RTL and testbench
==================================

# comparator_bist

Clocked built-in self-test sequencer for the 4-bit signed/unsigned comparator. On `start` it drives every `{c, A, B}` combination, 512 vectors, into a comparator instance. For each vector it waits a programmable settle time, samples `F1/F2/F3`, and checks them against an internal golden model. It counts mismatches and latches the first failing vector, so comparator correctness can be checked on the board without a simulator.

## Interface
Parameters:
- `SETTLE`, default 1. Cycles between driving a vector and sampling the result. Legal range 1–15.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: begin a sweep. Sampled only in IDLE or DONE.
- `A` output 4: operand A to the comparator under test.
- `B` output 4: operand B to the comparator under test.
- `c` output 1: mode to the comparator under test. 0 = unsigned, 1 = two's-complement signed.
- `F1` input 1: comparator result, A > B.
- `F2` input 1: comparator result, A == B.
- `F3` input 1: comparator result, A < B.
- `busy` output 1: high in SETTLE and CHECK.
- `done` output 1: high in DONE.
- `pass` output 1: `done & (err_count == 0)`.
- `err_count` output 10: number of mismatching vectors. Range 0–512, no saturation needed.
- `fail_valid` output 1: at least one mismatch seen this sweep.
- `first_fail` output 9: `{c, A, B}` of the first mismatch. Valid while `fail_valid` is high.

## Operation
- Vector index `idx[8:0]`. Outputs are driven as `{c, A, B} = idx`, straight from a register, so the sweep order is 0…511. Vectors 0–255 are unsigned; 256–511 are signed.
- Expected result, one-hot `{F1, F2, F3}`:
  - unsigned: compare A and B as 0–15;
  - signed: compare A and B as −8…7.
- A vector mismatches if the sampled `{F1, F2, F3}` differs from the expected value in any bit. This includes all-zero and multi-hot results.
- FSM states: IDLE, SETTLE, CHECK, DONE.
  - IDLE, `start`=1: clear `idx`, `err_count`, `fail_valid`, `first_fail`; set settle counter to 0; go to SETTLE.
  - SETTLE: increment the settle counter. When it reaches `SETTLE`−1, go to CHECK.
  - CHECK: sample F and compare. On a mismatch, increment `err_count`; if `fail_valid` is 0, latch `first_fail = idx` and set `fail_valid`. Then:
    - if `idx` is 511, go to DONE and hold `idx`;
    - otherwise increment `idx`, clear the settle counter, and go to SETTLE.
  - DONE: results hold. `start`=1 restarts the sweep exactly as from IDLE.
- `start` is ignored in SETTLE and CHECK.

## Timing
- Reset values: state IDLE, `idx`=0 (so `A`=0, `B`=0, `c`=0), `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_valid`=0, `first_fail`=0.
- Each vector takes `SETTLE`+1 cycles: `SETTLE` cycles in SETTLE plus 1 in CHECK.
- `busy` rises in the cycle after `start` is sampled. `done` rises 512·(`SETTLE`+1) cycles after that.
- A new vector appears on `A/B/c` in the cycle after the preceding CHECK. The comparator under test is combinational, so `SETTLE`=1 is sufficient.
- `err_count`, `fail_valid` and `first_fail` update in the cycle after the CHECK they belong to.
- Reset asserted mid-sweep forces all reset values immediately (asynchronous). No partial results are retained.
- `start` held high continuously in DONE restarts the sweep each time DONE is reached.

## Structure
- Shared package holds:
  - state encoding constants: IDLE, SETTLE, CHECK, DONE;
  - `VEC_W` = 9;
  - `ERR_W` = 10.
- One sub-module, `comparator_ref`: a combinational golden model with inputs `A`, `B`, `c` and a 3-bit one-hot expected output. It is instantiated once inside the BIST.
- The comparator under test is connected externally. In the top level, `comparator_bist` and `comparator` are wired together directly.

## Test plan
- Correct comparator, `SETTLE`=1, pulse `start` → `done` high 1024 cycles later; `err_count`=0, `pass`=1, `fail_valid`=0.
- Comparator that ignores `c` (always unsigned) → `err_count`=128, `first_fail`=9'd264 (`c`=1, `A`=0, `B`=8, expected F=100), `pass`=0.
- Comparator with `F2` stuck at 0 → `err_count`=32, `first_fail`=0.
- `SETTLE`=3, correct comparator → `done` 2048 cycles after `start`. `A/B/c` are stable for 4 cycles per vector, incrementing in index order.
- `start` pulsed again mid-sweep → ignored; completion cycle unchanged. `start` in DONE → counters clear and a full new sweep runs.
- `rst` asserted at vector 100 → all outputs take reset values immediately, with `A/B/c`=0. A following `start` runs a full 512-vector sweep.

Source files
------------

// File: rtl/comparator_bist_pkg.sv
// rtl/comparator_bist_pkg.sv - shared constants and state encoding for the comparator BIST
package comparator_bist_pkg;

    localparam int VEC_W = 9;
    localparam int ERR_W = 10;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/comparator_ref.sv
// rtl/comparator_ref.sv - combinational golden model of the 4-bit signed/unsigned comparator
module comparator_ref (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       c,
    output logic [2:0] exp_f
);

    logic signed [4:0] a_ext;
    logic signed [4:0] b_ext;

    // Extend to 5 bits: sign-extend in signed mode, zero-extend otherwise, then compare once
    always_comb begin
        a_ext    = {c & A[3], A};
        b_ext    = {c & B[3], B};
        exp_f    = 3'b000;
        exp_f[2] = (a_ext > b_ext);
        exp_f[1] = (a_ext == b_ext);
        exp_f[0] = (a_ext < b_ext);
    end

endmodule

// File: rtl/comparator_bist.sv
// rtl/comparator_bist.sv - exhaustive 512-vector self-test sequencer for the comparator
module comparator_bist
    import comparator_bist_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [3:0]       A,
    output logic [3:0]       B,
    output logic             c,
    input  logic             F1,
    input  logic             F2,
    input  logic             F3,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [VEC_W-1:0] first_fail
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [VEC_W-1:0] IDX_LAST    = {VEC_W{1'b1}};

    state_e             state_q;
    logic [VEC_W-1:0]   idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ERR_W-1:0]   err_q;
    logic               fv_q;
    logic [VEC_W-1:0]   ff_q;
    logic               busy_q;
    logic               done_q;

    logic [2:0]         exp_f;
    logic               mismatch;
    logic [ERR_W-1:0]   err_d;
    logic [VEC_W-1:0]   idx_d;

    comparator_ref u_ref (
        .A     (idx_q[7:4]),
        .B     (idx_q[3:0]),
        .c     (idx_q[8]),
        .exp_f (exp_f)
    );

    // Any bit difference counts, so all-zero and multi-hot responses are caught too
    always_comb begin
        mismatch = ({F1, F2, F3} != exp_f);
        err_d    = err_q + ERR_W'(1);
        idx_d    = idx_q + VEC_W'(1);
    end

    // Sweep FSM: outputs are registered alongside the state so they change on state entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            ff_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        err_q   <= '0;
                        fv_q    <= 1'b0;
                        ff_q    <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_q <= ST_CHECK;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        err_q <= err_d;
                        if (!fv_q) begin
                            fv_q <= 1'b1;
                            ff_q <= idx_q;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q   <= idx_d;
                        cnt_q   <= '0;
                        state_q <= ST_SETTLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign c          = idx_q[8];
    assign A          = idx_q[7:4];
    assign B          = idx_q[3:0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = done_q & (err_q == '0);
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign first_fail = ff_q;

endmodule

// File: tb/tb_comparator_bist.sv
// tb/tb_comparator_bist.sv - self-checking bench for comparator_bist with faultable comparator model
module tb_comparator_bist;

    localparam int M_OK   = 0;
    localparam int M_IGNC = 1;
    localparam int M_F2S  = 2;
    localparam int M_RAND = 3;

    logic clk = 1'b0;
    logic rst;
    logic start1, start3;
    logic [3:0] a1, b1, a3, b3;
    logic c1, c3;
    logic f1_1, f2_1, f3_1, f1_3, f2_3, f3_3;
    logic busy1, done1, pass1, fv1, busy3, done3, pass3, fv3;
    logic [9:0] err1, err3;
    logic [8:0] ff1, ff3;

    int mode;
    logic [2:0] mask [512];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    function automatic logic [2:0] golden(input logic cm, input logic [3:0] a, input logic [3:0] b);
        int av, bv;
        av = int'(a);
        bv = int'(b);
        if (cm) begin
            if (av > 7) av = av - 16;
            if (bv > 7) bv = bv - 16;
        end
        return {av > bv, av == bv, av < bv};
    endfunction

    function automatic logic [2:0] cut(input int md, input logic cm, input logic [3:0] a,
                                       input logic [3:0] b, input logic [2:0] m);
        case (md)
            M_IGNC:  return golden(1'b0, a, b);
            M_F2S:   return golden(cm, a, b) & 3'b101;
            M_RAND:  return golden(cm, a, b) ^ m;
            default: return golden(cm, a, b);
        endcase
    endfunction

    assign {f1_1, f2_1, f3_1} = cut(mode, c1, a1, b1, mask[{c1, a1, b1}]);
    assign {f1_3, f2_3, f3_3} = cut(mode, c3, a3, b3, mask[{c3, a3, b3}]);

    comparator_bist #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .c(c1),
        .F1(f1_1), .F2(f2_1), .F3(f3_1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_valid(fv1), .first_fail(ff1)
    );

    comparator_bist #(.SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .A(a3), .B(b3), .c(c3),
        .F1(f1_3), .F2(f2_3), .F3(f3_3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .fail_valid(fv3), .first_fail(ff3)
    );

    function automatic int g_vec(input int s);  return (s == 1) ? int'({c1, a1, b1}) : int'({c3, a3, b3}); endfunction
    function automatic int g_busy(input int s); return (s == 1) ? int'(busy1) : int'(busy3); endfunction
    function automatic int g_done(input int s); return (s == 1) ? int'(done1) : int'(done3); endfunction
    function automatic int g_pass(input int s); return (s == 1) ? int'(pass1) : int'(pass3); endfunction
    function automatic int g_err(input int s);  return (s == 1) ? int'(err1) : int'(err3); endfunction
    function automatic int g_fv(input int s);   return (s == 1) ? int'(fv1) : int'(fv3); endfunction
    function automatic int g_ff(input int s);   return (s == 1) ? int'(ff1) : int'(ff3); endfunction

    task automatic set_start(input int s, input logic v);
        if (s == 1) start1 = v;
        else        start3 = v;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Pulses start, then follows the sweep until done; tracks vector order and hold length
    task automatic do_sweep(input int s, input int mid, output int cycles, output int stab_bad);
        int prev, cur, run;
        @(negedge clk);
        set_start(s, 1'b1);
        @(posedge clk);
        #1;
        set_start(s, 1'b0);
        check("busy_after_start", g_busy(s), 1);
        check("err_cleared_on_start", g_err(s), 0);
        check("fv_cleared_on_start", g_fv(s), 0);
        cycles   = 0;
        stab_bad = 0;
        prev     = g_vec(s);
        run      = 1;
        if (prev != 0) stab_bad++;
        while (g_done(s) == 0 && cycles < 5000) begin
            if (mid > 0) set_start(s, cycles == mid);
            @(posedge clk);
            #1;
            cycles++;
            cur = g_vec(s);
            if (cur == prev) begin
                run++;
            end else begin
                if (cur != prev + 1 || run != s + 1) stab_bad++;
                prev = cur;
                run  = 1;
            end
        end
        set_start(s, 1'b0);
        if (prev != 511) stab_bad++;
    endtask

    typedef struct {
        int sel;
        int md;
        int exp_err;
        int exp_ff;
        int exp_fv;
        int exp_pass;
    } vec_t;

    vec_t tbl [6];

    task automatic check_results(input int s, input int cycles, input int stab,
                                 input int e_err, input int e_ff, input int e_fv, input int e_pass);
        check("done_latency", cycles, 512 * (s + 1));
        check("vector_order_hold", stab, 0);
        check("err_count", g_err(s), e_err);
        check("fail_valid", g_fv(s), e_fv);
        check("first_fail", g_ff(s), e_ff);
        check("pass", g_pass(s), e_pass);
        check("busy_low_in_done", g_busy(s), 0);
    endtask

    initial begin
        int cyc, stab, n, e_err, e_ff;
        rst    = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        mode   = M_OK;
        foreach (mask[i]) mask[i] = 3'd0;

        tbl[0] = '{1, M_OK,   0,   0,   0, 1};
        tbl[1] = '{1, M_IGNC, 128, 264, 1, 0};
        tbl[2] = '{1, M_F2S,  32,  0,   1, 0};
        tbl[3] = '{3, M_OK,   0,   0,   0, 1};
        tbl[4] = '{3, M_IGNC, 128, 264, 1, 0};
        tbl[5] = '{3, M_F2S,  32,  0,   1, 0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_vec", g_vec(1), 0);
        check("rst_busy", g_busy(1), 0);
        check("rst_done", g_done(1), 0);
        check("rst_pass", g_pass(1), 0);
        check("rst_err", g_err(1), 0);
        check("rst_fv", g_fv(1), 0);
        check("rst_ff", g_ff(1), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", g_busy(3), 0);
        check("idle_done", g_done(3), 0);

        for (int i = 0; i < 6; i++) begin
            mode = tbl[i].md;
            do_sweep(tbl[i].sel, 0, cyc, stab);
            check_results(tbl[i].sel, cyc, stab, tbl[i].exp_err, tbl[i].exp_ff,
                          tbl[i].exp_fv, tbl[i].exp_pass);
        end

        // Randomly planted faults; expected counts come from the fault map itself
        for (int it = 0; it < 4; it++) begin
            e_err = 0;
            e_ff  = -1;
            foreach (mask[i]) begin
                mask[i] = ($urandom_range(0, 31) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
                if (mask[i] != 3'd0) begin
                    e_err++;
                    if (e_ff < 0) e_ff = i;
                end
            end
            mode = M_RAND;
            do_sweep((it % 2 == 0) ? 1 : 3, 0, cyc, stab);
            check_results((it % 2 == 0) ? 1 : 3, cyc, stab, e_err,
                          (e_ff < 0) ? 0 : e_ff, (e_err > 0) ? 1 : 0, (e_err == 0) ? 1 : 0);
        end

        // Start pulsed mid-sweep is ignored; previous results were failing so start-in-DONE must clear
        mode = M_IGNC;
        do_sweep(1, 0, cyc, stab);
        check("pre_restart_err", g_err(1), 128);
        mode = M_OK;
        do_sweep(1, 300, cyc, stab);
        check_results(1, cyc, stab, 0, 0, 0, 1);

        // Asynchronous reset at vector 100 wipes everything mid-sweep
        mode = M_F2S;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        n = 0;
        while (g_vec(1) != 100 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reached_vec100", g_vec(1), 100);
        check("err_before_rst", g_err(1), 6);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_vec", g_vec(1), 0);
        check("async_rst_busy", g_busy(1), 0);
        check("async_rst_done", g_done(1), 0);
        check("async_rst_err", g_err(1), 0);
        check("async_rst_fv", g_fv(1), 0);
        check("async_rst_ff", g_ff(1), 0);
        @(negedge clk);
        rst  = 1'b0;
        mode = M_OK;
        do_sweep(1, 0, cyc, stab);
        check_results(1, cyc, stab, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
